icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter NFRAMES, default 16, number of direct-mapped one-word frames (power of two, 2..256).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 SHALL have port imemaddr  input  32  datapath word address; bits [1:0] ignored.
REQ-006 SHALL have port ihit  output  1  imemload valid this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word to datapath.
REQ-008 SHALL have port iREN  output  1  memory-side read request.
REQ-009 SHALL have port iaddr  output  32  memory-side word address, bits [1:0] = 0.
REQ-010 SHALL have port iwait  input  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0.
REQ-011 SHALL have port iload  input  32  memory read data.
REQ-012 SHALL have port hit_count  output  32  count of completed hits.
REQ-013 SHALL have port miss_count  output  32  count of misses that entered FILL.

Function
REQ-014 SHALL split imemaddr as index = [IW+1:2], tag = [31:IW+2], IW = log2(NFRAMES); each frame holds valid, tag, data.
REQ-015 SHALL implement two states: IDLE and FILL.
REQ-016 IDLE, imemREN=1, frame valid and tag equal: ihit=1, imemload=frame data, same cycle (zero latency), state stays IDLE.
REQ-017 IDLE, imemREN=1, miss: ihit=0, latch imemaddr word-aligned into miss_addr, state -> FILL next edge, miss_count += 1.
REQ-018 IDLE, imemREN=0: ihit=0, iREN=0, no state change.
REQ-019 FILL: iREN=1, iaddr=miss_addr; iREN SHALL NOT be asserted in IDLE.
REQ-020 FILL, iwait=1: hold state, iREN and iaddr unchanged.
REQ-021 FILL, iwait=0: write iload, miss_addr tag, valid=1 into frame at miss_addr index on that edge; state -> IDLE.
REQ-022 FILL completion cycle: if imemREN=1 and imemaddr[31:2]=miss_addr[31:2], ihit=1 and imemload=iload (bypass) that cycle; otherwise ihit=0.
REQ-023 imemREN dropping or imemaddr changing during FILL SHALL NOT abort the fill; frame is still written on iwait=0.
REQ-024 ihit SHALL be 0 in every FILL cycle except per REQ-022.
REQ-025 imemload SHALL be 0 whenever ihit=0.
REQ-026 hit_count SHALL increment by 1 on every edge ending a cycle with ihit=1 (including bypass); both counters saturate at 32'hFFFFFFFF.
REQ-027 Filling a valid frame with a different tag SHALL overwrite it (no write-back; instruction side is read-only).
REQ-028 Aliasing addresses (same index, different tag) alternating SHALL miss on every access.

Reset
REQ-029 RST=1 at an edge SHALL clear all valid bits, state -> IDLE, miss_addr -> 0, hit_count -> 0, miss_count -> 0.
REQ-030 During and right after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-031 RST asserted mid-FILL SHALL abort the fill: no frame written, iREN=0 in the cycle after the reset edge.
REQ-032 RST SHALL take priority over a coincident iwait=0 fill completion.
REQ-033 Frame data and tag arrays need no reset; only valid bits gate hits.

Verification
REQ-034 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN=1, iaddr=0x40 for 4 cycles; ihit=1, imemload=0x8C220004 in 4th; miss_count=1, hit_count=1.
REQ-035 Warm hit: repeat 0x00000040 -> ihit=1 same cycle, imemload=0x8C220004, iREN=0; hit_count=2.
REQ-036 Conflict: NFRAMES=16, access 0x00000040 then 0x00000440 then 0x00000040 -> three misses, each frame 0 overwrite; miss_count=3 after sequence.
REQ-037 Redirect mid-fill: miss on 0x100, change imemaddr to 0x200 before iwait=0 -> frame for 0x100 written, ihit=0 on completion; next cycle 0x200 misses and enters FILL.
REQ-038 Reset mid-fill: miss on 0x80, assert RST with iwait=0 -> no write; after release, 0x80 misses again (miss_count=1 post-reset).
REQ-039 Byte offset: imemaddr=0x00000043 after 0x40 is cached -> ihit=1, iaddr bits [1:0] always 0 on fills.

Source files
------------

// File: rtl/icache_if.sv
// icache_if: datapath-side and memory-side signals of the instruction cache
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    modport master(output imemREN, imemaddr, iwait, iload, input ihit, imemload, iREN, iaddr);
    modport slave(input imemREN, imemaddr, iwait, iload, output ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped one-word-frame instruction cache with zero-latency hits
module icache_dm #(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    icache_if.slave     bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IW = $clog2(NFRAMES);
    localparam int TW = 30 - IW;
    typedef enum logic {IDLE, FILL} state_t;
    state_t             state;
    logic [NFRAMES-1:0] valid;
    logic [TW-1:0]      tags [NFRAMES];
    logic [31:0]        data [NFRAMES];
    logic [31:0]        miss_addr;
    logic [IW-1:0]      idx, midx;
    logic [TW-1:0]      tag;
    logic               fill, hit_i, byp, miss, unused;
    assign idx    = bus.imemaddr[IW+1:2];
    assign tag    = bus.imemaddr[31:IW+2];
    assign midx   = miss_addr[IW+1:2];
    assign unused = ^bus.imemaddr[1:0];
    assign fill   = state == FILL;
    assign hit_i  = !fill && bus.imemREN && valid[idx] && tags[idx] == tag;
    // Fill completion forwards iload straight to the datapath when it still wants that word
    assign byp    = fill && !bus.iwait && bus.imemREN && bus.imemaddr[31:2] == miss_addr[31:2];
    assign miss   = !fill && bus.imemREN && !hit_i;
    assign bus.ihit     = !RST && (hit_i || byp);
    assign bus.imemload = !bus.ihit ? '0 : byp ? bus.iload : data[idx];
    assign bus.iREN     = !RST && fill;
    assign bus.iaddr    = bus.iREN ? miss_addr : '0;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            miss_addr  <= '0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (bus.ihit) hit_count <= hit_count + 32'(hit_count != '1);
            if (miss) begin
                state      <= FILL;
                miss_addr  <= {bus.imemaddr[31:2], 2'b00};
                miss_count <= miss_count + 32'(miss_count != '1);
            end
            if (fill && !bus.iwait) begin
                valid[midx] <= 1'b1;
                tags[midx]  <= miss_addr[31:IW+2];
                data[midx]  <= bus.iload;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed vector table plus a variable-latency fill sequence for icache_dm
module tb_icache_dm;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] hit_count, miss_count;
    int          errors = 0;
    int          checks = 0;
    icache_if bus();
    icache_dm #(.NFRAMES(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
    );
    always #5 CLK = ~CLK;
    typedef struct {
        logic        rst, ren;
        logic [31:0] addr;
        logic        iw;
        logic [31:0] ild;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr, e_hc, e_mc;
    } vec_t;
    vec_t v[$];
    function automatic vec_t mk(logic rst, logic ren, logic [31:0] addr, logic iw, logic [31:0] ild,
                                logic hit, logic [31:0] load, logic iren, logic [31:0] ia,
                                logic [31:0] hc, logic [31:0] mc);
        vec_t r;
        r.rst = rst; r.ren = ren; r.addr = addr; r.iw = iw; r.ild = ild;
        r.e_hit = hit; r.e_load = load; r.e_iren = iren; r.e_iaddr = ia; r.e_hc = hc; r.e_mc = mc;
        return r;
    endfunction
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    initial begin
        bit got;
        //          rst ren addr          iw  iload          hit load           iren iaddr         hc  mc
        v.push_back(mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0));
        v.push_back(mk(0, 1, 32'h40,       1, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0));
        v.push_back(mk(0, 1, 32'h40,       1, 32'h0,         0, 32'h0,         1, 32'h40,        0, 1));
        v.push_back(mk(0, 1, 32'h40,       1, 32'h0,         0, 32'h0,         1, 32'h40,        0, 1));
        v.push_back(mk(0, 1, 32'h40,       1, 32'h0,         0, 32'h0,         1, 32'h40,        0, 1));
        v.push_back(mk(0, 1, 32'h40,       0, 32'h8C220004,  1, 32'h8C220004,  1, 32'h40,        0, 1));
        v.push_back(mk(0, 1, 32'h40,       1, 32'h0,         1, 32'h8C220004,  0, 32'h0,         1, 1));
        v.push_back(mk(0, 1, 32'h43,       1, 32'h0,         1, 32'h8C220004,  0, 32'h0,         2, 1));
        v.push_back(mk(0, 0, 32'h0,        1, 32'h0,         0, 32'h0,         0, 32'h0,         3, 1));
        v.push_back(mk(0, 1, 32'h440,      0, 32'h0,         0, 32'h0,         0, 32'h0,         3, 1));
        v.push_back(mk(0, 1, 32'h440,      0, 32'h11111111,  1, 32'h11111111,  1, 32'h440,       3, 2));
        v.push_back(mk(0, 1, 32'h40,       0, 32'h0,         0, 32'h0,         0, 32'h0,         4, 2));
        v.push_back(mk(0, 1, 32'h40,       0, 32'h22222222,  1, 32'h22222222,  1, 32'h40,        4, 3));
        v.push_back(mk(0, 1, 32'h440,      0, 32'h0,         0, 32'h0,         0, 32'h0,         5, 3));
        v.push_back(mk(0, 0, 32'h0,        0, 32'h33333333,  0, 32'h0,         1, 32'h440,       5, 4));
        v.push_back(mk(0, 1, 32'h440,      1, 32'h0,         1, 32'h33333333,  0, 32'h0,         5, 4));
        v.push_back(mk(0, 1, 32'h100,      1, 32'h0,         0, 32'h0,         0, 32'h0,         6, 4));
        v.push_back(mk(0, 1, 32'h200,      1, 32'h0,         0, 32'h0,         1, 32'h100,       6, 5));
        v.push_back(mk(0, 1, 32'h200,      0, 32'h44444444,  0, 32'h0,         1, 32'h100,       6, 5));
        v.push_back(mk(0, 1, 32'h200,      1, 32'h0,         0, 32'h0,         0, 32'h0,         6, 5));
        v.push_back(mk(0, 1, 32'h200,      1, 32'h0,         0, 32'h0,         1, 32'h200,       6, 6));
        v.push_back(mk(0, 1, 32'h100,      0, 32'h55555555,  0, 32'h0,         1, 32'h200,       6, 6));
        v.push_back(mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0,         6, 6));
        v.push_back(mk(0, 1, 32'h44,       0, 32'h0,         0, 32'h0,         0, 32'h0,         6, 6));
        v.push_back(mk(0, 1, 32'h44,       0, 32'hAAAA0044,  1, 32'hAAAA0044,  1, 32'h44,        6, 7));
        v.push_back(mk(0, 1, 32'h44,       1, 32'h0,         1, 32'hAAAA0044,  0, 32'h0,         7, 7));
        v.push_back(mk(0, 1, 32'h80,       1, 32'h0,         0, 32'h0,         0, 32'h0,         8, 7));
        v.push_back(mk(1, 1, 32'h80,       0, 32'h66666666,  0, 32'h0,         0, 32'h0,         8, 8));
        v.push_back(mk(0, 1, 32'h80,       1, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0));
        v.push_back(mk(0, 1, 32'h80,       0, 32'h77777777,  1, 32'h77777777,  1, 32'h80,        0, 1));
        v.push_back(mk(0, 1, 32'h80,       1, 32'h0,         1, 32'h77777777,  0, 32'h0,         1, 1));
        v.push_back(mk(0, 1, 32'h44,       1, 32'h0,         0, 32'h0,         0, 32'h0,         2, 1));
        v.push_back(mk(0, 0, 32'h0,        1, 32'h0,         0, 32'h0,         1, 32'h44,        2, 2));
        v.push_back(mk(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         1, 32'h44,        2, 2));
        v.push_back(mk(0, 0, 32'h0,        1, 32'h0,         0, 32'h0,         0, 32'h0,         2, 2));
        RST = 1'b1; bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;
        @(negedge CLK);
        #1;
        chk("rst_ihit", 32'(bus.ihit), 0);
        chk("rst_imemload", bus.imemload, 0);
        chk("rst_iren", 32'(bus.iREN), 0);
        chk("rst_iaddr", bus.iaddr, 0);
        chk("rst_hc", hit_count, 0);
        chk("rst_mc", miss_count, 0);
        foreach (v[i]) begin
            @(negedge CLK);
            RST = v[i].rst; bus.imemREN = v[i].ren; bus.imemaddr = v[i].addr;
            bus.iwait = v[i].iw; bus.iload = v[i].ild;
            #1;
            chk($sformatf("r%0d_ihit", i), 32'(bus.ihit), 32'(v[i].e_hit));
            chk($sformatf("r%0d_imemload", i), bus.imemload, v[i].e_load);
            chk($sformatf("r%0d_iren", i), 32'(bus.iREN), 32'(v[i].e_iren));
            chk($sformatf("r%0d_iaddr", i), bus.iaddr, v[i].e_iaddr);
            chk($sformatf("r%0d_hc", i), hit_count, v[i].e_hc);
            chk($sformatf("r%0d_mc", i), miss_count, v[i].e_mc);
        end
        // Long memory stall: completion must land exactly when iwait first drops
        @(negedge CLK);
        bus.imemREN = 1'b1; bus.imemaddr = 32'h3C0; bus.iwait = 1'b1;
        #1;
        chk("seq_miss_ihit", 32'(bus.ihit), 0);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            bus.iwait = c < 5;
            bus.iload = 32'hCAFEF00D;
            #1;
            if (bus.ihit) begin
                got = 1'b1;
                chk("seq_latency", c, 5);
                chk("seq_load", bus.imemload, 32'hCAFEF00D);
            end else if (!bus.iREN || bus.iaddr != 32'h3C0) begin
                chk("seq_fill_iren", 32'(bus.iREN), 1);
                chk("seq_fill_iaddr", bus.iaddr, 32'h3C0);
            end
        end
        if (!got) chk("seq_timeout", 0, 1);
        @(negedge CLK);
        bus.iwait = 1'b1;
        #1;
        chk("seq_hit_again", 32'(bus.ihit), 1);
        chk("seq_hc", hit_count, 3);
        chk("seq_mc", miss_count, 3);
        @(negedge CLK);
        bus.imemaddr = 32'h80;
        #1;
        chk("seq_alias_miss", 32'(bus.ihit), 0);
        chk("seq_alias_load", bus.imemload, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
